// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial ALU sequencer driving an external 4-bit ALU slice, plus the ALU4Bit slice itself.
// Optional feature: define ALU_SEQ_ABORT_EN to add the abort port and shadow-register result commit.

module ALU4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  input  logic       cin,
  input  logic       less,
  output logic [3:0] result,
  output logic       cout,
  output logic       set,
  output logic       overflow
);

  logic [3:0] w_bb;
  logic [4:0] w_sum;

  // op[2] inverts b so SUB/SLT become a + ~b + cin with cin=1 on the first nibble
  always_comb begin
    w_bb     = op[2] ? ~b : b;
    w_sum    = {1'b0, a} + {1'b0, w_bb} + {4'b0000, cin};
    cout     = w_sum[4];
    overflow = (a[3] == w_bb[3]) && (w_sum[3] != a[3]);
    set      = w_sum[3] ^ overflow;
    case (op[1:0])
      2'b00:   result = a & w_bb;
      2'b01:   result = a | w_bb;
      2'b10:   result = w_sum[3:0];
      default: result = {3'b000, less};
    endcase
  end

endmodule

module alu_nibble_sequencer #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef ALU_SEQ_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] y,
  output logic         cout,
  output logic         overflow,
  output logic         zero,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [2:0]   alu_op,
  output logic         alu_cin,
  output logic         alu_less,
  input  logic [3:0]   alu_result,
  input  logic         alu_cout,
  input  logic         alu_set,
  input  logic         alu_overflow
);

  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [W-1:0]   r_aQ;
  logic [W-1:0]   r_bQ;
  logic [2:0]     r_opQ;
  logic [IW-1:0]  r_idx;
  logic           r_carry;
  logic [W-1:0]   r_y;
  logic           r_cout;
  logic           r_overflow;
  logic           r_zero;
`ifdef ALU_SEQ_ABORT_EN
  logic [W-1:0]   r_shadow;
`endif

  logic           w_accept;
  logic           w_last;
  logic           w_abort;
  logic           w_slt;
  logic           w_arith;
  logic [W-1:0]   w_yBase;
  logic [W-1:0]   w_yMerged;
  logic [W-1:0]   w_yFinal;

  always_comb begin
    w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    w_last   = (r_idx == IW'(NIBBLES - 1));
    w_slt    = (r_opQ == 3'b111);
    w_arith  = (r_opQ == 3'b010) || (r_opQ == 3'b110) || (r_opQ == 3'b111);
`ifdef ALU_SEQ_ABORT_EN
    w_abort  = abort && (r_state == RUN);
    w_yBase  = r_shadow;
`else
    w_abort  = 1'b0;
    w_yBase  = r_y;
`endif
  end

  // SLT discards the per-nibble results and keeps only the sign-corrected set of the MSB nibble
  always_comb begin
    w_yMerged                = w_yBase;
    w_yMerged[4*r_idx +: 4]  = alu_result;
    w_yFinal                 = w_slt ? {{(W-1){1'b0}}, alu_set} : w_yMerged;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = RUN;
      RUN: begin
        if (w_abort)     w_nextState = IDLE;
        else if (w_last) w_nextState = DONE;
      end
      DONE:    w_nextState = w_accept ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // r_carry is frozen on the last nibble so alu_cin keeps its final value while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_aQ       <= '0;
      r_bQ       <= '0;
      r_opQ      <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_y        <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
`ifdef ALU_SEQ_ABORT_EN
      r_shadow   <= '0;
`endif
    end else if (w_accept) begin
      r_aQ  <= a;
      r_bQ  <= b;
      r_opQ <= op;
      r_idx <= '0;
    end else if ((r_state == RUN) && !w_abort) begin
      if (!w_last) begin
        r_idx   <= r_idx + IW'(1);
        r_carry <= alu_cout;
      end
`ifdef ALU_SEQ_ABORT_EN
      r_shadow <= w_yMerged;
`else
      if (!w_slt) r_y <= w_yMerged;
`endif
      if (w_last) begin
        r_y        <= w_yFinal;
        r_cout     <= alu_cout;
        r_overflow <= w_arith & alu_overflow;
        r_zero     <= (w_yFinal == '0);
      end
    end
  end

  always_comb begin
    busy     = (r_state == RUN);
    done     = (r_state == DONE);
    y        = r_y;
    cout     = r_cout;
    overflow = r_overflow;
    zero     = r_zero;
    alu_a    = r_aQ[4*r_idx +: 4];
    alu_b    = r_bQ[4*r_idx +: 4];
    alu_op   = r_opQ;
    alu_cin  = (r_idx == '0) ? r_opQ[2] : r_carry;
    alu_less = 1'b0;
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed self-checking bench for alu_nibble_sequencer (NIBBLES=4) with an ALU4Bit slice.
// Abort checks are compiled in when ALU_SEQ_ABORT_EN is defined.

module tb_alu_nibble_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
`ifdef ALU_SEQ_ABORT_EN
  logic        abort;
`endif
  logic        busy;
  logic        done;
  logic [15:0] y;
  logic        cout;
  logic        overflow;
  logic        zero;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_cin;
  logic        alu_less;
  logic [3:0]  alu_result;
  logic        alu_cout;
  logic        alu_set;
  logic        alu_overflow;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .a            (a),
    .b            (b),
`ifdef ALU_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .busy         (busy),
    .done         (done),
    .y            (y),
    .cout         (cout),
    .overflow     (overflow),
    .zero         (zero),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_cin      (alu_cin),
    .alu_less     (alu_less),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_set      (alu_set),
    .alu_overflow (alu_overflow)
  );

  ALU4Bit slice (
    .a        (alu_a),
    .b        (alu_b),
    .op       (alu_op),
    .cin      (alu_cin),
    .less     (alu_less),
    .result   (alu_result),
    .cout     (alu_cout),
    .set      (alu_set),
    .overflow (alu_overflow)
  );

  // Samples are taken 1 time unit after the rising edge, well clear of it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
      else begin
        nMismatched++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic [2:0] opIn, input logic [15:0] aIn, input logic [15:0] bIn);
    op    = opIn;
    a     = aIn;
    b     = bIn;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int cycles = 0;
    while (!done && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = 16'h0000;
    b     = 16'h0000;
`ifdef ALU_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_y", {16'd0, y}, 32'h0000);
    checkOutput("rst_flags", {29'd0, cout, overflow, zero}, 32'b001);
    reset = 1'b0;
    tick();

    // ADD 0x00FF + 0x0001 with latency check and operand changes after accept
    applyStimulus(3'b010, 16'h00FF, 16'h0001);
    a = 16'hAAAA;
    b = 16'h5555;
    op = 3'b001;
    checkOutput("add_busy0", {31'd0, busy}, 32'd1);
    checkOutput("add_nib0", {21'd0, alu_op, alu_cin, alu_a, alu_b}, {21'd0, 3'b010, 1'b0, 4'hF, 4'h1});
    tick();
    checkOutput("add_nib1", {23'd0, alu_cin, alu_a, alu_b}, {23'd0, 1'b1, 4'hF, 4'h0});
    checkOutput("add_done_e1", {31'd0, done}, 32'd0);
    tick();
    tick();
    checkOutput("add_done_e3", {30'd0, busy, done}, 32'b10);
    tick();
    checkOutput("add_done_e4", {30'd0, busy, done}, 32'b01);
    checkOutput("add_y", {16'd0, y}, 32'h0100);
    checkOutput("add_flags", {29'd0, cout, overflow, zero}, 32'b000);
    tick();
    checkOutput("add_idle", {30'd0, busy, done}, 32'b00);
    checkOutput("add_y_hold", {16'd0, y}, 32'h0100);

`ifdef ALU_SEQ_ABORT_EN
    // Abort mid-operation leaves the previous result untouched
    applyStimulus(3'b010, 16'h1111, 16'h2222);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_state", {30'd0, busy, done}, 32'b00);
    checkOutput("abort_y", {16'd0, y}, 32'h0100);
    tick();
    checkOutput("abort_nodone", {30'd0, busy, done}, 32'b00);
`endif

    applyStimulus(3'b110, 16'h1234, 16'h1234);
    waitDone("sub_done");
    checkOutput("sub_y", {16'd0, y}, 32'h0000);
    checkOutput("sub_flags", {29'd0, cout, overflow, zero}, 32'b101);

    applyStimulus(3'b010, 16'h7FFF, 16'h0001);
    waitDone("ovf_done");
    checkOutput("ovf_y", {16'd0, y}, 32'h8000);
    checkOutput("ovf_flags", {29'd0, cout, overflow, zero}, 32'b010);

    applyStimulus(3'b111, 16'h8000, 16'h0001);
    waitDone("slt1_done");
    checkOutput("slt1_y", {16'd0, y}, 32'h0001);
    checkOutput("slt1_zero", {31'd0, zero}, 32'd0);

    applyStimulus(3'b111, 16'h0001, 16'h8000);
    waitDone("slt0_done");
    checkOutput("slt0_y", {16'd0, y}, 32'h0000);
    checkOutput("slt0_zero", {31'd0, zero}, 32'd1);
    tick();

    // Start held high every cycle: AND then OR back-to-back
    op    = 3'b000;
    a     = 16'hF0F0;
    b     = 16'hFF00;
    start = 1'b1;
    tick();
    checkOutput("b2b_busy0", {31'd0, busy}, 32'd1);
    tick();
    tick();
    checkOutput("b2b_run2", {22'd0, busy, done, alu_a, alu_b}, {22'd0, 1'b1, 1'b0, 4'h0, 4'hF});
    tick();
    tick();
    checkOutput("b2b_and_done", {31'd0, done}, 32'd1);
    checkOutput("b2b_and_y", {16'd0, y}, 32'hF000);
    op = 3'b001;
    tick();
    checkOutput("b2b_noidle", {30'd0, busy, done}, 32'b10);
    tick();
    tick();
    tick();
    tick();
    checkOutput("b2b_or_done", {31'd0, done}, 32'd1);
    checkOutput("b2b_or_y", {16'd0, y}, 32'hFFF0);
    start = 1'b0;
    tick();

    // Asynchronous reset in the middle of RUN
    applyStimulus(3'b010, 16'h1111, 16'h2222);
    tick();
    tick();
    reset = 1'b1;
    #1;
    checkOutput("mrst_state", {30'd0, busy, done}, 32'b00);
    checkOutput("mrst_y", {16'd0, y}, 32'h0000);
    checkOutput("mrst_zero", {31'd0, zero}, 32'd1);
    #2;
    reset = 1'b0;
    tick();
    applyStimulus(3'b010, 16'h1111, 16'h2222);
    waitDone("post_done");
    checkOutput("post_y", {16'd0, y}, 32'h3333);
    checkOutput("post_flags", {29'd0, cout, overflow, zero}, 32'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
